// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// wb_cmd_master : FIFO-queued Wishbone master with ack and irq timeouts
// Revision 1.0
// ============================================================================
module wb_cmd_master #(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              irq_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [ADDR_WIDTH-1:0]             req_addr_i,
    input  logic [DATA_WIDTH-1:0]             req_data_i,
    input  logic                              req_we_i,
    input  logic                              req_wait_irq_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [DATA_WIDTH-1:0]             rsp_data_o,
    output logic                              rsp_err_o,
    output logic                              cyc_o,
    output logic                              stb_o,
    output logic                              we_o,
    output logic [ADDR_WIDTH-1:0]             adr_o,
    output logic [DATA_WIDTH-1:0]             dat_o,
    input  logic [DATA_WIDTH-1:0]             dat_i,
    input  logic                              ack_i,
    output logic                              busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH + 2;
    localparam logic [LW-1:0] C_FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [TW-1:0] C_TMAX     = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUS      = 2'd1,
        S_IRQ_WAIT = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    wait_q, wait_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [EW-1:0]           mem_q [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]           level_q;

    logic                    w_push, w_pop;
    logic [EW-1:0]           w_head;
    logic [ADDR_WIDTH-1:0]   w_head_addr;
    logic [DATA_WIDTH-1:0]   w_head_data;
    logic                    w_head_we, w_head_wait;
    logic [TW-1:0]           w_timer_inc;
    logic                    w_expire;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    assign req_ready_o = (level_q != C_FULL_LVL);
    assign w_push      = req_valid_i && req_ready_o;
    assign w_pop       = (state_q == S_IDLE) && (level_q != '0);

    assign w_head = mem_q[rd_ptr_q];
    assign {w_head_addr, w_head_data, w_head_we, w_head_wait} = w_head;

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {req_addr_i, req_data_i, req_we_i, req_wait_irq_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (w_push && !w_pop)      level_q <= level_q + LW'(1);
            else if (!w_push && w_pop) level_q <= level_q - LW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    assign w_timer_inc = (timer_q == C_TMAX) ? timer_q : timer_q + TW'(1);
    assign w_expire    = (w_timer_inc == C_TMAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            wait_q      <= 1'b0;
            timer_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            wait_q      <= wait_d;
            timer_q     <= timer_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        wait_d      = wait_q;
        timer_d     = timer_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    state_d = S_BUS;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = w_head_we;
                    adr_d   = w_head_addr;
                    dat_d   = w_head_data;
                    wait_d  = w_head_we && w_head_wait;
                    timer_d = '0;
                end
            end
            S_BUS: begin
                if (ack_i || w_expire) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    adr_d = '0;
                    dat_d = '0;
                end
                // An ack on the expiry edge still wins over the timeout.
                if (ack_i) begin
                    if (we_q && wait_q) begin
                        state_d = S_IRQ_WAIT;
                        timer_d = '0;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_data_d  = we_q ? '0 : dat_i;
                    end
                end else if (w_expire) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                end else begin
                    timer_d = w_timer_inc;
                end
            end
            S_IRQ_WAIT: begin
                if (irq_i || w_expire) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !irq_i;
                    rsp_data_d  = '0;
                end else begin
                    timer_d = w_timer_inc;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cyc_o       = cyc_q;
    assign stb_o       = stb_q;
    assign we_o        = we_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign level_o     = level_q;
    assign busy_o      = (state_q != S_IDLE) || (level_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// tb_wb_cmd_master : directed bench with response/bus scoreboard
// Revision 1.0
// ============================================================================
module tb_wb_cmd_master;

    localparam int TO = 24;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       irq_i = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready_o;
    logic [1:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_we = 1'b0;
    logic       req_wi = 1'b0;
    logic       rsp_valid_o;
    logic       rsp_rdy = 1'b1;
    logic [7:0] rsp_data_o;
    logic       rsp_err_o;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       ack_i;
    logic       busy_o;
    logic [2:0] level_o;

    always #5 clk = ~clk;

    wb_cmd_master #(
        .ADDR_WIDTH(2), .DATA_WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .irq_i(irq_i),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_we_i(req_we),
        .req_wait_irq_i(req_wi),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_rdy),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i),
        .busy_o(busy_o), .level_o(level_o)
    );

    // Slave: register file, acks after ack_wait cycles of strobe.
    logic [7:0] smem [4];
    int         scnt = 0;
    bit         ack_en = 1'b1;
    int         ack_wait = 0;

    assign ack_i = stb_o && ack_en && (scnt == ack_wait);
    assign dat_i = stb_o ? smem[adr_o] : 8'h00;

    always @(posedge clk) begin
        if (!stb_o) scnt <= 0;
        else        scnt <= scnt + 1;
        if (stb_o && ack_i && we_o) smem[adr_o] <= dat_o;
    end

    // Model: ordered expected bus requests and responses.
    typedef struct { logic [1:0] a; logic [7:0] d; logic we; } breq_t;
    typedef struct { logic [7:0] d; logic e; } rsp_t;
    breq_t      bus_q[$];
    rsp_t       exp_q[$];
    logic [7:0] shadow [4];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic void model_push(input logic [1:0] a, input logic [7:0] d,
                                       input logic we, input logic wi,
                                       input bit acked, input bit irq_ok);
        breq_t b;
        rsp_t  r;
        b.a = a; b.d = d; b.we = we;
        bus_q.push_back(b);
        if (!acked) begin
            r.d = 8'h00; r.e = 1'b1;
        end else if (!we) begin
            r.d = shadow[a]; r.e = 1'b0;
        end else begin
            shadow[a] = d;
            r.d = 8'h00;
            r.e = wi ? !irq_ok : 1'b0;
        end
        exp_q.push_back(r);
    endfunction

    // Per-cycle compare against the model.
    logic       prv_v = 1'b0, prv_r = 1'b0, prv_e = 1'b0, prv_cyc = 1'b0;
    logic [7:0] prv_d = '0;

    always @(negedge clk) begin
        breq_t b;
        rsp_t  r;
        if (rst_i) begin
            prv_v   = 1'b0;
            prv_cyc = 1'b0;
        end else begin
            chk("stb_eq_cyc", stb_o, cyc_o);
            chk("ready_decode", req_ready_o, level_o != 3'd4);
            if (!cyc_o) chk("idle_bus", {we_o, adr_o, dat_o}, 32'h0);
            if (cyc_o && rsp_valid_o) fail("cyc_during_rsp");
            if (cyc_o && !prv_cyc) begin
                if (bus_q.size() == 0) fail("unexpected_cyc");
                else begin
                    b = bus_q.pop_front();
                    chk("bus_req", {we_o, adr_o, dat_o}, {b.we, b.a, b.d});
                end
            end
            if (prv_v && !prv_r)
                chk("rsp_hold", {rsp_valid_o, rsp_err_o, rsp_data_o}, {1'b1, prv_e, prv_d});
            if (rsp_valid_o && rsp_rdy) begin
                if (exp_q.size() == 0) fail("unexpected_rsp");
                else begin
                    r = exp_q.pop_front();
                    chk("rsp", {rsp_err_o, rsp_data_o}, {r.e, r.d});
                end
            end
            prv_v   = rsp_valid_o;
            prv_r   = rsp_rdy;
            prv_e   = rsp_err_o;
            prv_d   = rsp_data_o;
            prv_cyc = cyc_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] a, input logic [7:0] d, input logic we,
                        input logic wi, input bit acked, input bit irq_ok);
        int g = 0;
        while (!req_ready_o && g < 200) begin tick(); g++; end
        if (g >= 200) fail("push_ready");
        req_valid = 1'b1; req_addr = a; req_data = d; req_we = we; req_wi = wi;
        @(posedge clk);
        model_push(a, d, we, wi, acked, irq_ok);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_cyc(input logic lvl);
        int g = 0;
        while (cyc_o !== lvl && g < 200) begin tick(); g++; end
        if (g >= 200) fail("wait_cyc");
    endtask

    task automatic wait_rsp();
        int g = 0;
        while (!rsp_valid_o && g < 200) begin tick(); g++; end
        if (g >= 200) fail("wait_rsp");
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy_o && g < 300) begin tick(); g++; end
        if (g >= 300) fail("wait_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        smem[0] = 8'hC0; smem[1] = 8'h5A; smem[2] = 8'h00; smem[3] = 8'h00;
        for (int i = 0; i < 4; i++) shadow[i] = smem[i];

        // Reset values
        repeat (3) tick();
        chk("rst_bus", {cyc_o, stb_o, we_o, adr_o, dat_o}, 32'h0);
        chk("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, 32'h0);
        chk("rst_level_busy", {busy_o, level_o}, 32'h0);
        chk("rst_ready", req_ready_o, 1);
        rst_i = 1'b0;
        tick();

        // Zero-wait latency: push at N, cyc at N+1, response at N+2
        ack_wait = 0;
        push(2'd1, 8'h00, 1'b0, 1'b0, 1, 1);
        chk("lat_n_cyc", cyc_o, 0);
        tick();
        chk("lat_n1_cyc", {cyc_o, rsp_valid_o}, 2'b10);
        tick();
        chk("lat_n2", {cyc_o, rsp_valid_o, rsp_err_o, rsp_data_o}, {3'b010, 8'h5A});
        wait_idle();

        // Read CSR with three wait states
        ack_wait = 3;
        push(2'd0, 8'h00, 1'b0, 1'b0, 1, 1);
        wait_cyc(1'b1);
        n = 0;
        while (cyc_o && n < 100) begin n++; tick(); end
        chk("csr_cyc_len", n, 4);
        chk("csr_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b10, 8'hC0});
        wait_idle();

        // Command write completing on irq after 20 quiet cycles
        ack_wait = 1;
        push(2'd2, 8'h06, 1'b1, 1'b1, 1, 1);
        wait_cyc(1'b1);
        wait_cyc(1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("irq_quiet", {cyc_o, rsp_valid_o}, 0);
            tick();
        end
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        chk("irq_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b10, 8'h00});
        wait_idle();

        // irq already high on entry completes on the first edge
        ack_wait = 0;
        irq_i = 1'b1;
        push(2'd2, 8'h01, 1'b1, 1'b1, 1, 1);
        wait_cyc(1'b1);
        wait_cyc(1'b0);
        chk("irq_pre_entry", rsp_valid_o, 0);
        tick();
        chk("irq_pre_rsp", {rsp_valid_o, rsp_err_o}, 2'b10);
        irq_i = 1'b0;
        wait_idle();

        // irq never arrives: error TIMEOUT edges after entering the wait
        push(2'd3, 8'hA5, 1'b1, 1'b1, 1, 0);
        wait_cyc(1'b1);
        wait_cyc(1'b0);
        n = 0;
        while (!rsp_valid_o && n < 100) begin tick(); n++; end
        chk("irq_to_len", n, TO);
        chk("irq_to_rsp", {rsp_err_o, rsp_data_o}, {1'b1, 8'h00});
        wait_idle();

        // wait_irq is ignored for reads
        push(2'd2, 8'h00, 1'b0, 1'b1, 1, 1);
        wait_idle();

        // Ack timeout, then the queued read runs normally
        ack_en = 1'b0;
        push(2'd3, 8'h11, 1'b1, 1'b0, 0, 1);
        push(2'd1, 8'h00, 1'b0, 1'b0, 1, 1);
        wait_cyc(1'b1);
        n = 0;
        while (cyc_o && n < 100) begin n++; tick(); end
        chk("ack_to_len", n, TO);
        chk("ack_to_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b11, 8'h00});
        ack_en = 1'b1;
        wait_idle();

        // Backpressure and FIFO full
        rsp_rdy = 1'b0;
        push(2'd0, 8'h00, 1'b0, 1'b0, 1, 1);
        wait_rsp();
        for (int i = 0; i < 10; i++) begin
            chk("bp_nocyc", cyc_o, 0);
            tick();
        end
        chk("bp_data", {rsp_valid_o, rsp_data_o}, {1'b1, 8'hC0});
        push(2'd1, 8'h33, 1'b1, 1'b0, 1, 1);
        push(2'd1, 8'h00, 1'b0, 1'b0, 1, 1);
        push(2'd3, 8'h44, 1'b1, 1'b0, 1, 1);
        push(2'd3, 8'h00, 1'b0, 1'b0, 1, 1);
        chk("full_level", {req_ready_o, level_o}, {1'b0, 3'd4});
        req_valid = 1'b1; req_addr = 2'd0; req_data = 8'hEE; req_we = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("full_refused", level_o, 4);
        rsp_rdy = 1'b1;
        wait_idle();
        chk("drain_level", level_o, 0);
        chk("drain_model", exp_q.size(), 0);

        // Reset mid-transaction
        ack_en = 1'b0;
        push(2'd0, 8'h00, 1'b0, 1'b0, 1, 1);
        push(2'd1, 8'h00, 1'b0, 1'b0, 1, 1);
        wait_cyc(1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_bus", {cyc_o, stb_o, we_o, adr_o, dat_o}, 32'h0);
        chk("mid_rst_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, 32'h0);
        chk("mid_rst_lvl", {req_ready_o, busy_o, level_o}, {2'b10, 3'd0});
        bus_q.delete();
        exp_q.delete();
        tick();
        tick();
        rst_i = 1'b0;
        ack_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            chk("post_rst_quiet", {cyc_o, rsp_valid_o}, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
